// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined skid buffer.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default payload width and slice count
//   slice_state_e                 : fill level of one two-entry slice
//   occ_width()                   : bit width of the occupancy counter
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;
  localparam int unsigned DEFAULT_DEPTH = 2;

  // A slice holds zero, one (main only) or two (main + skid) beats.
  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_ONE   = 2'd1,
    SLICE_TWO   = 2'd2
  } slice_state_e;

  // Occupancy ranges 0..2*depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/skid_slice.sv
// One register slice with a main entry and a skid entry (capacity 2).
// The upstream ready is a flop, so no combinational path runs from
// out_ready back to in_ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous discard of both entries
//   in_valid, data_in   : upstream beat
//   in_ready            : registered upstream ready
//   out_valid, data_out : downstream beat (data_out = main register)
//   out_ready           : downstream accept
module skid_slice
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready
);

  slice_state_e     state, state_next;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             ready_q;
  logic             up_xfer, dn_xfer;
  logic             load_main, main_from_skid, load_skid;

  assign in_ready  = ready_q;
  assign out_valid = (state != SLICE_EMPTY);
  assign data_out  = main_q;
  assign up_xfer   = in_valid & ready_q;
  assign dn_xfer   = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Flush beats any transfer; data registers keep their contents.
      state_next = SLICE_EMPTY;
    end else begin
      case (state)
        SLICE_EMPTY: begin
          if (up_xfer) begin
            state_next = SLICE_ONE;
            load_main  = 1'b1;
          end
        end
        SLICE_ONE: begin
          case ({up_xfer, dn_xfer})
            2'b10: begin
              // Main is stalled: park the new beat in the skid entry.
              state_next = SLICE_TWO;
              load_skid  = 1'b1;
            end
            2'b01:   state_next = SLICE_EMPTY;
            2'b11:   load_main  = 1'b1;
            default: state_next = SLICE_ONE;
          endcase
        end
        SLICE_TWO: begin
          // ready_q is low here, so only a drain can happen.
          if (dn_xfer) begin
            state_next     = SLICE_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = SLICE_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so
  // every flop samples pre-edge values; combinational logic uses blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SLICE_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      // Ready drops the cycle after the skid fills, returns after it drains.
      ready_q <= (state_next != SLICE_TWO);
    end
  end

  // NOTE: the payload registers are reset on purpose, because data_out must
  // read zero while reset is held; otherwise data flops need no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= data_in;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= data_in;
      end
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Chain of DEPTH skid slices with flush fan-out and an occupancy counter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   data_in, in_valid   : upstream beat
//   in_ready            : registered upstream ready (first slice)
//   data_out, out_valid : downstream beat (last slice)
//   out_ready           : downstream accept
//   flush               : synchronous discard of all held beats
//   occupancy           : registered count of beats held (0..2*DEPTH)
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  // Stage i is the input side of slice i; stage DEPTH is the block output.
  logic [DEPTH:0]   stage_valid;
  logic [DEPTH:0]   stage_ready;
  logic [WIDTH-1:0] stage_data [DEPTH+1];
  logic             accept, drain;

  assign stage_valid[0]     = in_valid;
  assign stage_data[0]      = data_in;
  assign stage_ready[DEPTH] = out_ready;
  assign in_ready           = stage_ready[0];
  assign out_valid          = stage_valid[DEPTH];
  assign data_out           = stage_data[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    skid_slice #(.WIDTH(WIDTH)) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (stage_valid[i]),
      .data_in   (stage_data[i]),
      .in_ready  (stage_ready[i]),
      .data_out  (stage_data[i+1]),
      .out_valid (stage_valid[i+1]),
      .out_ready (stage_ready[i+1])
    );
  end

  assign accept = in_valid & stage_ready[0];
  assign drain  = stage_valid[DEPTH] & out_ready;

  // Counts transfers at the block boundary; a flush discards both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      case ({accept, drain})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: a queue-based reference model
// fed at every upstream accept, and a monitor that pops and compares on
// every downstream transfer. Extra DEPTH=1 and DEPTH=8 instances check
// the acceptance limit.
module tb_pipe_skid_buffer;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;
  localparam logic [63:0] DEAD_BEAT = 64'hDEAD_BEEF_0000_0001;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [2:0]       occupancy;

  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_flush;
  logic [15:0] d1_data_in, d1_data_out;
  logic [1:0]  d1_occupancy;
  logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready, d8_flush;
  logic [15:0] d8_data_in, d8_data_out;
  logic [4:0]  d8_occupancy;

  pipe_skid_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .occupancy(occupancy)
  );

  pipe_skid_buffer #(.WIDTH(16), .DEPTH(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .data_in(d1_data_in), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .data_out(d1_data_out), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .flush(d1_flush), .occupancy(d1_occupancy)
  );

  pipe_skid_buffer #(.WIDTH(16), .DEPTH(8)) dut_d8 (
    .clk(clk), .rst_n(rst_n), .data_in(d8_data_in), .in_valid(d8_in_valid),
    .in_ready(d8_in_ready), .data_out(d8_data_out), .out_valid(d8_out_valid),
    .out_ready(d8_out_ready), .flush(d8_flush), .occupancy(d8_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered queue of accepted beats tagged with the
  // edge number at which they were accepted.
  typedef struct {
    logic [63:0] data;
    int          edge_no;
  } beat_t;

  beat_t       model_q[$];
  int          cyc = 0;
  int          pops = 0;
  int          peak_occ = 0;
  bit          exact_lat = 1'b0;
  bit          seen_dead = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act on.
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      model_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("occupancy", 64'(occupancy), 64'(model_q.size()));
      if (model_q.size() == 2 * DEPTH) check("full_in_ready", 64'(in_ready), 64'd0);
      if (prev_stall) begin
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_data_out", data_out, prev_data);
      end
      if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
      if (flush) begin
        model_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          pops++;
          if (data_out == DEAD_BEAT) seen_dead = 1'b1;
          if (model_q.size() == 0) begin
            check("beat_without_accept", 64'(out_valid), 64'd0);
          end else begin
            b = model_q.pop_front();
            check("data_out_order", data_out, b.data);
            if (exact_lat) check("latency", 64'(cyc + 1 - b.edge_no), 64'(DEPTH));
          end
        end
        if (in_valid && in_ready) model_q.push_back(beat_t'{data: data_in, edge_no: cyc + 1});
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = data_out;
    end
  end

  task automatic wait_drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (model_q.size() == 0 && !out_valid) break;
      step();
    end
    check("drain_complete", 64'(model_q.size()), 64'd0);
  endtask

  // Offer beats base, base+1, ... until n are accepted or the budget ends.
  task automatic send_n(input int n, input logic [63:0] base, input int budget);
    int  nacc;
    bit  acc;
    nacc = 0;
    for (int c = 0; c < budget && nacc < n; c++) begin
      in_valid = 1'b1;
      data_in  = base + 64'(nacc);
      acc      = in_ready;
      step();
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    check("send_n_accepted", 64'(nacc), 64'(n));
  endtask

  initial begin
    int p0, nacc, next, sent, n1, n8, e1, e8;
    bit acc, a1, a8;

    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0; flush = 1'b0;
    d1_in_valid = 1'b0; d1_data_in = '0; d1_out_ready = 1'b0; d1_flush = 1'b0;
    d8_in_valid = 1'b0; d8_data_in = '0; d8_out_ready = 1'b0; d8_flush = 1'b0;
    repeat (3) step();

    // Reset state while rst_n is held low.
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    rst_n = 1'b1;
    check("release_in_ready_pre_edge", 64'(in_ready), 64'd0);
    step();
    check("release_in_ready_first_edge", 64'(in_ready), 64'd1);

    // Streaming: 8 back-to-back beats, out_ready held high.
    out_ready = 1'b1; exact_lat = 1'b1; peak_occ = 0; p0 = pops;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      data_in  = 64'(i);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    wait_drain(20);
    exact_lat = 1'b0;
    check("stream_peak_occupancy", 64'(peak_occ), 64'd2);
    check("stream_pops", 64'(pops - p0), 64'd8);

    // Backpressure: offer 6 beats with out_ready low; only 4 fit.
    out_ready = 1'b0; nacc = 0; next = 1; p0 = pops;
    for (int c = 0; c < 8; c++) begin
      if (nacc == 4) check("bp_in_ready_low", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      data_in  = 64'(100 + next);
      acc      = in_ready;
      step();
      if (acc) begin
        nacc++;
        next++;
      end
    end
    check("bp_accepts", 64'(nacc), 64'd4);
    check("bp_occupancy", 64'(occupancy), 64'd4);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && next <= 6; c++) begin
      in_valid = 1'b1;
      data_in  = 64'(100 + next);
      acc      = in_ready;
      step();
      if (acc) next++;
    end
    in_valid = 1'b0;
    check("bp_remaining_accepted", 64'(next), 64'd7);
    wait_drain(40);
    check("bp_pops", 64'(pops - p0), 64'd6);

    // Random traffic with 50% out_ready duty.
    p0 = pops; sent = 0; in_valid = 1'b0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        data_in  = {$urandom, $urandom};
      end
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("rand_sent", 64'(sent), 64'd1000);
    wait_drain(100);
    check("rand_pops", 64'(pops - p0), 64'd1000);

    // Flush with 3 beats held, colliding with an accept and a drain.
    out_ready = 1'b0;
    send_n(3, 64'h200, 20);
    check("flush_pre_occupancy", 64'(occupancy), 64'd3);
    flush = 1'b1; in_valid = 1'b1; data_in = DEAD_BEAT; out_ready = 1'b1;
    check("flush_offer_ready", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_occupancy", 64'(occupancy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    p0 = pops;
    send_n(2, 64'h300, 20);
    wait_drain(20);
    check("post_flush_pops", 64'(pops - p0), 64'd2);

    // Asynchronous reset mid-cycle with 4 beats held.
    out_ready = 1'b0;
    send_n(4, 64'h400, 20);
    check("rst_mid_pre_occupancy", 64'(occupancy), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    check("rst_mid_occupancy", 64'(occupancy), 64'd0);
    check("rst_mid_data_out", data_out, 64'd0);
    step();
    step();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("rst_mid_release_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      check("rst_mid_no_stale_beat", 64'(out_valid), 64'd0);
      step();
    end
    p0 = pops;
    send_n(2, 64'h500, 20);
    wait_drain(20);
    check("post_reset_pops", 64'(pops - p0), 64'd2);

    // Acceptance limit for DEPTH=1 and DEPTH=8 builds.
    d1_out_ready = 1'b0; d8_out_ready = 1'b0; n1 = 0; n8 = 0;
    for (int c = 0; c < 40; c++) begin
      d1_in_valid = 1'b1; d1_data_in = 16'(n1 + 1);
      d8_in_valid = 1'b1; d8_data_in = 16'(n8 + 1);
      a1 = d1_in_ready;
      a8 = d8_in_ready;
      step();
      if (a1) n1++;
      if (a8) n8++;
    end
    d1_in_valid = 1'b0; d8_in_valid = 1'b0;
    check("d1_accepts", 64'(n1), 64'd2);
    check("d8_accepts", 64'(n8), 64'd16);
    check("d1_occupancy", 64'(d1_occupancy), 64'd2);
    check("d8_occupancy", 64'(d8_occupancy), 64'd16);
    check("d1_in_ready_full", 64'(d1_in_ready), 64'd0);
    check("d8_in_ready_full", 64'(d8_in_ready), 64'd0);
    d1_out_ready = 1'b1; d8_out_ready = 1'b1; e1 = 1; e8 = 1;
    repeat (40) begin
      @(negedge clk);
      if (d1_out_valid) begin
        check("d1_order", 64'(d1_data_out), 64'(e1));
        e1++;
      end
      if (d8_out_valid) begin
        check("d8_order", 64'(d8_data_out), 64'(e8));
        e8++;
      end
    end
    check("d1_all_out", 64'(e1), 64'd3);
    check("d8_all_out", 64'(e8), 64'd17);

    check("dead_beat_absent", 64'(seen_dead), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
